// File: rtl/cu_arith_pkg.sv
// Shared arithmetic definitions for the CU datapath blocks.
//   state_t  : serial-adder control states (IDLE -> RUN -> DONE -> IDLE)
//   CU_ALU_W : default operand width
package cu_arith_pkg;

  localparam int CU_ALU_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_1b.sv
// One-bit full-adder cell, purely combinational.
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_8b.sv
// Bit-serial two-operand adder, LSB first, one bit per clock.
// Operands arrive on an in_valid/in_ready handshake, and the result leaves on
// an out_valid/out_ready handshake. out_valid rises WIDTH cycles after the
// accepting edge. Operations are not pipelined.
// Optional build macro:
//   ADDER_SAT_EN : clamp sum to all-ones when the carry out is set.
// Ports:
//   clk, rst_n           : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (A, B, cin)
//   out_valid / out_ready: result handshake (sum, carry_out)
//   busy                 : high whenever the state is not IDLE
module serial_adder_8b
  import cu_arith_pkg::*;
#(
  parameter int WIDTH = CU_ALU_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_s_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_cout;
  logic             w_last;

  full_adder_1b u_fa (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_next = ST_RUN;
      ST_RUN:  if (w_last)    w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_s_sr  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == ST_IDLE && in_valid) begin
      r_a_sr  <= A;
      r_b_sr  <= B;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      // Sum bits enter at the MSB; after WIDTH shifts bit 0 holds the first one.
      r_s_sr  <= {w_s, r_s_sr[WIDTH-1:1]};
      r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_carry <= w_cout;
      if (!w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);

  always_comb begin
    sum       = '0;
    carry_out = 1'b0;
    if (out_valid) begin
      sum       = r_s_sr;
      carry_out = r_carry;
`ifdef ADDER_SAT_EN
      // Clamp at the output only; r_s_sr keeps the wrapped value.
      if (r_carry) begin
        sum = '1;
      end
`endif
    end
  end

endmodule
